// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter and sequencer for the M9K program/data RAM (RAM clock domain).
// Round-robin grant with bounded lock ownership, fixed-latency read return, out-of-range flagging.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_LIMIT   = 12288,
    parameter int READ_LATENCY = 2,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                  ram_clock,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  a_lock,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic                  b_lock,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  overflow,
    output logic [ADDR_WIDTH-1:0] overflow_addr
);

    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ADDR_WIDTH:0]   LIMIT    = (ADDR_WIDTH + 1)'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic                    rr_q, rr_d;          // 1'b0: A wins contention, 1'b1: B wins
    logic [CNT_W-1:0]        lock_cnt_q, lock_cnt_d, lock_cnt_inc_s;
    logic                    gnt_a_s, gnt_b_s, any_gnt_s;
    logic                    sel_we_s, sel_lock_s, in_range_s, own_lock_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [ADDR_WIDTH-1:0]   wraddr_q, rdaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_port_q, tag_oor_q;
    logic                    a_rvalid_q, b_rvalid_q;
    logic [DATA_WIDTH-1:0]   a_rdata_q, b_rdata_q;
    logic                    overflow_q;
    logic [ADDR_WIDTH-1:0]   overflow_addr_q;

    // Grant decision: owner-only while locked, round-robin on contention in IDLE.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (!rst_n) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_req && b_req) begin
                        gnt_a_s = ~rr_q;
                        gnt_b_s = rr_q;
                    end else begin
                        gnt_a_s = a_req;
                        gnt_b_s = b_req;
                    end
                end
                OWN_A:   gnt_a_s = a_req;
                OWN_B:   gnt_b_s = b_req;
                default: begin
                    gnt_a_s = 1'b0;
                    gnt_b_s = 1'b0;
                end
            endcase
        end
    end

    // Mux the granted port's request fields.
    always_comb begin
        any_gnt_s = gnt_a_s | gnt_b_s;
        if (gnt_b_s) begin
            sel_we_s    = b_we;
            sel_lock_s  = b_lock;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_we;
            sel_lock_s  = a_lock;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
        in_range_s = ({1'b0, sel_addr_s} < LIMIT);
    end

    // RAM port drive; addresses hold their last value when not used.
    always_comb begin
        ram_wren = any_gnt_s & sel_we_s & in_range_s;
        if (ram_wren) begin
            ram_wraddress = sel_addr_s;
            ram_data      = sel_wdata_s;
        end else begin
            ram_wraddress = wraddr_q;
            ram_data      = wdata_q;
        end
        if (any_gnt_s && !sel_we_s) begin
            ram_rdaddress = sel_addr_s;
        end else begin
            ram_rdaddress = rdaddr_q;
        end
    end

    // Ownership, round-robin pointer and saturating lock counter next state.
    always_comb begin
        state_d        = state_q;
        lock_cnt_d     = lock_cnt_q;
        lock_cnt_inc_s = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
        own_lock_s     = (state_q == OWN_B) ? b_lock : a_lock;
        if (any_gnt_s) begin
            rr_d = ~gnt_b_s;
        end else begin
            rr_d = rr_q;
        end
        case (state_q)
            IDLE: begin
                if (any_gnt_s && sel_lock_s) begin
                    state_d    = gnt_b_s ? OWN_B : OWN_A;
                    lock_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_A, OWN_B: begin
                lock_cnt_d = lock_cnt_inc_s;
                if (lock_cnt_inc_s == CNT_LAST) begin
                    state_d = IDLE;
                    rr_d    = (state_q == OWN_A);
                end else if (!own_lock_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Control state and held RAM addresses.
    always_ff @(posedge ram_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            lock_cnt_q <= '0;
            wraddr_q   <= '0;
            rdaddr_q   <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
            wraddr_q   <= ram_wraddress;
            rdaddr_q   <= ram_rdaddress;
            wdata_q    <= ram_data;
        end
    end

    // Read tag pipeline tracks which port owns each in-flight read.
    always_ff @(posedge ram_clock or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q  <= '0;
            tag_port_q <= '0;
            tag_oor_q  <= '0;
        end else begin
            tag_vld_q[0]  <= any_gnt_s & ~sel_we_s;
            tag_port_q[0] <= gnt_b_s;
            tag_oor_q[0]  <= ~in_range_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_port_q[i] <= tag_port_q[i-1];
                tag_oor_q[i]  <= tag_oor_q[i-1];
            end
        end
    end

    // Read return: load the owning port's data register and pulse its rvalid.
    always_ff @(posedge ram_clock or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= tag_vld_q[READ_LATENCY-1] & ~tag_port_q[READ_LATENCY-1];
            b_rvalid_q <= tag_vld_q[READ_LATENCY-1] & tag_port_q[READ_LATENCY-1];
            if (tag_vld_q[READ_LATENCY-1] && !tag_port_q[READ_LATENCY-1]) begin
                a_rdata_q <= tag_oor_q[READ_LATENCY-1] ? '0 : ram_q;
            end else begin
                a_rdata_q <= a_rdata_q;
            end
            if (tag_vld_q[READ_LATENCY-1] && tag_port_q[READ_LATENCY-1]) begin
                b_rdata_q <= tag_oor_q[READ_LATENCY-1] ? '0 : ram_q;
            end else begin
                b_rdata_q <= b_rdata_q;
            end
        end
    end

    // Sticky overflow; the address is frozen at the first offending access.
    always_ff @(posedge ram_clock or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q      <= 1'b0;
            overflow_addr_q <= '0;
        end else if (any_gnt_s && !in_range_s) begin
            overflow_q <= 1'b1;
            if (!overflow_q) begin
                overflow_addr_q <= sel_addr_s;
            end else begin
                overflow_addr_q <= overflow_addr_q;
            end
        end else begin
            overflow_q      <= overflow_q;
            overflow_addr_q <= overflow_addr_q;
        end
    end

    assign a_gnt         = gnt_a_s;
    assign b_gnt         = gnt_b_s;
    assign a_rvalid      = a_rvalid_q;
    assign b_rvalid      = b_rvalid_q;
    assign a_rdata       = a_rdata_q;
    assign b_rdata       = b_rdata_q;
    assign overflow      = overflow_q;
    assign overflow_addr = overflow_addr_q;

endmodule
